frame_scan_ctrl: RTL and testbench
==================================

# frame_scan_ctrl

Frame scan controller that sequences the pixel-pair image datapath. It owns the frame timing: vertical start-up delay, per-line horizontal blanking, then two pixels per beat. It generates VSYNC/HSYNC, row/column, and a linear pixel address for the image memory. It sits between the frame source memory and the pixel consumer (processing/write stage), and it honours downstream backpressure.

## Interface
Parameters:
- WIDTH, 768, pixels per row; even, ≥2
- HEIGHT, 512, rows per frame; ≥1
- VSYNC_DELAY, 100, start-up cycles with VSYNC high; ≥1
- HSYNC_DELAY, 160, blanking cycles before each line; ≥1

Ports:
- HCLK  in  1  sole clock, rising edge
- HRESET  in  1  reset; synchronous, active-high
- start  in  1  begin one frame; sampled only in IDLE
- ready  in  1  consumer accepts current pixel pair
- VSYNC  out  1  high during the start-up delay
- HSYNC  out  1  pixel pair valid (high only in DATA)
- row  out  16  current row
- col  out  16  left-pixel column of current pair (always even)
- pix_idx  out  32  row*WIDTH + col
- busy  out  1  state ≠ IDLE
- ctrl_done  out  1  one-cycle pulse at end of frame
- frame_cnt  out  8  completed frames, wraps 255→0

## Operation
- All outputs are registered. Reset value of every output is 0; state resets to IDLE.
- States:
  - IDLE: wait for start.
  - VSYNC: count VSYNC_DELAY cycles, then go to HSYNC.
  - HSYNC: blank for HSYNC_DELAY cycles, then go to DATA.
  - DATA: present one pair per beat.
  - DONE: one cycle, then go to IDLE.
- IDLE→VSYNC on start=1. The delay counter clears on every state entry.
- DATA beat: a beat completes when HSYNC=1 and ready=1.
  - On a beat, col advances by 2.
  - On a beat with col=WIDTH-2: col goes to 0 and the row advances. The controller returns to HSYNC, or goes to DONE after the last row.
- ready=0 in DATA: row, col and pix_idx hold stable and HSYNC stays 1. ready is ignored outside DATA.
- In DONE: ctrl_done=1 and frame_cnt increments.
- pix_idx is maintained incrementally: +2 per beat, and it is recomputed at the row change. No multiplier.
- start outside IDLE is ignored, including the DONE cycle. Starts are not queued.
- HRESET=1 in any state: the next edge forces IDLE and all outputs to 0, including frame_cnt. The frame is abandoned.

## Timing
- start sampled high in IDLE at edge T:
  - VSYNC=1 for cycles T+1 … T+VSYNC_DELAY.
  - First blanking: T+VSYNC_DELAY+1 … T+VSYNC_DELAY+HSYNC_DELAY.
  - First HSYNC=1 at T+VSYNC_DELAY+HSYNC_DELAY+1.
- With ready held high, each line takes HSYNC_DELAY + WIDTH/2 cycles.
- ctrl_done fires at T + VSYNC_DELAY + HEIGHT*(HSYNC_DELAY+WIDTH/2) + 1.
- Each ready=0 cycle in DATA delays every later event by exactly one cycle.
- busy=1 from T+1 through the DONE cycle. The earliest next frame start is sampled the cycle after DONE.

## Configuration
- BOTTOM_UP_EN defined: rows scan HEIGHT-1 down to 0, matching bottom-up bitmap storage. pix_idx starts at (HEIGHT-1)*WIDTH and drops by 2*WIDTH at each row change, net of the in-row advance.
- BOTTOM_UP_EN undefined: rows scan 0 up to HEIGHT-1.
- Column order is left→right in both builds.

## Test plan
All tests use WIDTH=4, HEIGHT=2, VSYNC_DELAY=3, HSYNC_DELAY=2, BOTTOM_UP_EN undefined unless stated.
- Reset: HRESET=1 for 2 cycles with random start/ready → every output is 0, busy=0.
- Nominal frame: start at cycle 0, ready=1 →
  - VSYNC at cycles 1–3; blanking at 4–5.
  - HSYNC at 6–7 with pix_idx 0,2; blanking at 8–9; HSYNC at 10–11 with pix_idx 4,6.
  - ctrl_done at 12; frame_cnt=1.
- Backpressure: as the nominal frame, with ready=0 during cycles 7–9 → HSYNC stays 1 and col=2, pix_idx=2 hold through 7–9. The beat completes at 10 and ctrl_done fires at 15.
- Start handling:
  - start pulses at cycles 5 and 12 → ignored.
  - start at 13 → second frame, ctrl_done at 25, frame_cnt=2.
- Mid-frame reset: HRESET at cycle 10 (DATA, row 1) → all outputs 0 at 11. A start at 12 gives a full frame from row 0 with ctrl_done at 24.
- BOTTOM_UP_EN defined, nominal stimulus → pix_idx sequence 4,6,0,2 and row sequence 1,1,0,0; ctrl_done still at 12.

Source files
------------

// File: rtl/frame_scan_ctrl.sv
// frame_scan_ctrl: frame sequencer (VSYNC delay, per-line blanking, pixel-pair beats with backpressure); define BOTTOM_UP_EN to scan rows bottom-up
module frame_scan_ctrl #(
  parameter int WIDTH       = 768,
  parameter int HEIGHT      = 512,
  parameter int VSYNC_DELAY = 100,
  parameter int HSYNC_DELAY = 160
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic        ready,
  output logic        VSYNC,
  output logic        HSYNC,
  output logic [15:0] row,
  output logic [15:0] col,
  output logic [31:0] pix_idx,
  output logic        busy,
  output logic        ctrl_done,
  output logic [7:0]  frame_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_HSYNC, S_DATA, S_DONE} state_t;
  localparam logic [15:0] COL_LAST = 16'(WIDTH - 2);
`ifdef BOTTOM_UP_EN
  localparam logic [15:0] ROW_FIRST = 16'(HEIGHT - 1);
  localparam logic [15:0] ROW_LAST  = 16'd0;
  localparam logic [15:0] ROW_STEP  = 16'hFFFF;
  localparam logic [31:0] PIX_FIRST = 32'((HEIGHT - 1) * WIDTH);
  localparam logic [31:0] PIX_ROW   = 32'(2 - 2 * WIDTH);
`else
  localparam logic [15:0] ROW_FIRST = 16'd0;
  localparam logic [15:0] ROW_LAST  = 16'(HEIGHT - 1);
  localparam logic [15:0] ROW_STEP  = 16'd1;
  localparam logic [31:0] PIX_FIRST = 32'd0;
  localparam logic [31:0] PIX_ROW   = 32'd2;
`endif
  state_t      r_state;
  logic [31:0] r_cnt;
  logic        r_vsync;
  logic        r_hsync;
  logic [15:0] r_row;
  logic [15:0] r_col;
  logic [31:0] r_pix;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_fcnt;
  assign VSYNC     = r_vsync;
  assign HSYNC     = r_hsync;
  assign row       = r_row;
  assign col       = r_col;
  assign pix_idx   = r_pix;
  assign busy      = r_busy;
  assign ctrl_done = r_done;
  assign frame_cnt = r_fcnt;
  // frame state machine with registered outputs; the delay counter restarts on every state entry
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_vsync <= 1'b0;
      r_hsync <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
      r_pix   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fcnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_VSYNC;
          r_cnt   <= '0;
          r_vsync <= 1'b1;
          r_busy  <= 1'b1;
          r_row   <= ROW_FIRST;
          r_col   <= '0;
          r_pix   <= PIX_FIRST;
        end
        S_VSYNC: if (r_cnt == 32'(VSYNC_DELAY - 1)) begin
          r_state <= S_HSYNC;
          r_cnt   <= '0;
          r_vsync <= 1'b0;
        end else r_cnt <= r_cnt + 32'd1;
        S_HSYNC: if (r_cnt == 32'(HSYNC_DELAY - 1)) begin
          r_state <= S_DATA;
          r_cnt   <= '0;
          r_hsync <= 1'b1;
        end else r_cnt <= r_cnt + 32'd1;
        S_DATA: if (ready) begin
          if (r_col == COL_LAST) begin
            r_hsync <= 1'b0;
            r_cnt   <= '0;
            r_col   <= '0;
            if (r_row == ROW_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_fcnt  <= r_fcnt + 8'd1;
            end else begin
              r_state <= S_HSYNC;
              r_row   <= r_row + ROW_STEP;
              r_pix   <= r_pix + PIX_ROW;
            end
          end else begin
            r_col <= r_col + 16'd2;
            r_pix <= r_pix + 32'd2;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_scan_ctrl.sv
// tb_frame_scan_ctrl: scoreboard bench with a cycle-timeline reference model of the frame scan
module tb_frame_scan_ctrl;
  localparam int W = 4;
  localparam int H = 2;
  localparam int VD = 3;
  localparam int HD = 2;
  localparam int NCYC = 7000;
  localparam int NT = NCYC + 64;
  typedef struct {int cyc; int row; int col; int pix;} beat_t;
  typedef struct {int cyc; logic [7:0] fc;} done_t;
  logic clk = 1'b0;
  logic HRESET = 1'b1, start = 1'b0, ready = 1'b0;
  logic VSYNC, HSYNC, busy, ctrl_done;
  logic [15:0] row, col;
  logic [31:0] pix_idx;
  logic [7:0] frame_cnt;
  int cyc = -1;
  int checks = 0, errors = 0;
  int idle_from = 0;
  logic [7:0] fc_model = 8'd0;
  bit exp_vs [0:NT-1];
  bit exp_hs [0:NT-1];
  bit exp_busy [0:NT-1];
  bit exp_done [0:NT-1];
  bit rdy [0:NT-1];
  bit st [0:NT-1];
  bit rs [0:NT-1];
  bit rndst [0:NT-1];
  int sbeat [0:NT-1];
  int sn [0:NT-1];
  beat_t bq[$];
  done_t dq[$];
  beat_t b;
  done_t d;
  frame_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .VSYNC_DELAY(VD), .HSYNC_DELAY(HD)) dut (
    .HCLK(clk), .HRESET(HRESET), .start(start), .ready(ready),
    .VSYNC(VSYNC), .HSYNC(HSYNC), .row(row), .col(col), .pix_idx(pix_idx),
    .busy(busy), .ctrl_done(ctrl_done), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h", nm, cyc, act, exp);
    end
  endtask
  // Lay out the whole frame on the cycle timeline: VSYNC window, blanking, beats with stalls, done.
  task automatic plan_frame(input int t, input int sb, input int n, input bit rnd);
    int c, k, rv, s;
    c = t + 1;
    k = 0;
    for (int i = 0; i < VD; i++) begin exp_vs[c] = 1; exp_busy[c] = 1; c++; end
    for (int r = 0; r < H; r++) begin
`ifdef BOTTOM_UP_EN
      rv = H - 1 - r;
`else
      rv = r;
`endif
      for (int i = 0; i < HD; i++) begin exp_busy[c] = 1; c++; end
      for (int j = 0; j < W / 2; j++) begin
        s = rnd ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0) : ((k == sb) ? n : 0);
        repeat (s) begin exp_hs[c] = 1; exp_busy[c] = 1; rdy[c] = 0; c++; end
        exp_hs[c] = 1; exp_busy[c] = 1; rdy[c] = 1;
        bq.push_back('{c, rv, 2 * j, rv * W + 2 * j});
        c++;
        k++;
      end
    end
    exp_busy[c] = 1;
    exp_done[c] = 1;
    fc_model = fc_model + 8'd1;
    dq.push_back('{c, fc_model});
    idle_from = c + 1;
  endtask
  initial begin
    for (int c = 0; c < NT; c++) begin rdy[c] = 1'($urandom_range(0, 1)); sbeat[c] = -1; end
    st[0] = 1'($urandom_range(0, 1));
    st[1] = 1'($urandom_range(0, 1));
    rs[0] = 1; rs[1] = 1;
    st[3] = 1;
    st[20] = 1; sbeat[20] = 1; sn[20] = 3;
    st[40] = 1; st[45] = 1; st[52] = 1; st[53] = 1;
    st[70] = 1; rs[80] = 1; st[82] = 1;
    for (int c = 100; c < NCYC - 200; c++) begin
      st[c] = ($urandom_range(0, 1) == 1);
      rndst[c] = 1;
      if (c >= 4800) rs[c] = ($urandom_range(0, 149) == 0);
    end
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      HRESET = rs[c];
      start = st[c];
      if (rs[c]) begin
        for (int k = c + 1; k < NT; k++) begin exp_vs[k] = 0; exp_hs[k] = 0; exp_busy[k] = 0; exp_done[k] = 0; end
        while (bq.size() > 0 && bq[$].cyc > c) void'(bq.pop_back());
        while (dq.size() > 0 && dq[$].cyc > c) void'(dq.pop_back());
        fc_model = 8'd0;
        idle_from = c + 1;
      end else if (st[c] && c >= idle_from) plan_frame(c, sbeat[c], sn[c], rndst[c]);
      ready = rdy[c];
    end
    @(negedge clk);
    chk("beats_left", 64'(bq.size()), 64'd0);
    chk("dones_left", 64'(dq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  // Monitor: per-cycle flags against the timeline, beats and done pulses against the queues.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rs[cyc-1]) begin
        chk("rst_flags", 64'({VSYNC, HSYNC, busy, ctrl_done}), 64'd0);
        chk("rst_pos", {row, col, pix_idx}, 64'd0);
        chk("rst_fcnt", 64'(frame_cnt), 64'd0);
      end else
        chk("flags_vs_hs_busy_done", 64'({VSYNC, HSYNC, busy, ctrl_done}),
            64'({exp_vs[cyc], exp_hs[cyc], exp_busy[cyc], exp_done[cyc]}));
      if (HSYNC) begin
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected cycle %0d got pix %0d want no pair", cyc, pix_idx);
        end else begin
          b = bq[0];
          chk(ready ? "beat_pos" : "stall_hold", {row, col, pix_idx}, {16'(b.row), 16'(b.col), 32'(b.pix)});
          if (ready) begin
            chk("beat_cycle", 64'(cyc), 64'(b.cyc));
            void'(bq.pop_front());
          end
        end
      end
      if (ctrl_done) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected cycle %0d got frame_cnt %0d want no done", cyc, frame_cnt);
        end else begin
          d = dq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(d.cyc));
          chk("frame_cnt", 64'(frame_cnt), 64'(d.fc));
        end
      end
    end
  end
endmodule
